// File: rtl/uart_pkg.sv
// Shared UART definitions: register map, STATUS bit positions
// and the TX sequencer state type.
package uart_pkg;

    localparam logic [1:0] CONTROL_ADDR = 2'd0;
    localparam logic [1:0] DATA_TX_ADDR = 2'd1;
    localparam logic [1:0] STATUS_ADDR  = 2'd2;
    localparam logic [1:0] DATA_RX_ADDR = 2'd3;

    localparam int ST_DONE_BIT = 0;
    localparam int ST_BUSY_BIT = 1;

    typedef enum logic [2:0] {
        IDLE,
        WR_DATA,
        WR_START,
        WR_CLEAR,
        RD_BUSY,
        CHK_BUSY,
        RD_DONE,
        CHK_DONE
    } seq_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy output; DEPTH is a power of two.
// A push while full or a pop while empty is ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      level_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [AW:0]      level_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (level_q == (AW+1)'(DEPTH));
    assign empty_o = (level_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rptr_q];
    assign level_o = level_q;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (do_pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_sequencer.sv
// Streams buffered bytes to the UART through its register file.
// Optional poll timeout: define UART_SEQ_TIMEOUT_EN.
module uart_tx_sequencer
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter logic [WIDTH-1:0] CTRL_START = 8'h01,
`ifdef UART_SEQ_TIMEOUT_EN
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000,
`endif
    localparam int LW = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             enable,
    input  logic             s_valid,
    input  logic [WIDTH-1:0] s_data,
    output logic             s_ready,
    output logic             rf_wr_en,
    output logic [1:0]       rf_wr_addr,
    output logic [WIDTH-1:0] rf_wr_data,
    output logic             rf_rd_en,
    output logic [1:0]       rf_rd_addr,
    input  logic [WIDTH-1:0] rf_rd_data,
`ifdef UART_SEQ_TIMEOUT_EN
    output logic             timeout_err,
`endif
    output logic             seq_busy,
    output logic             byte_sent,
    output logic [LW-1:0]    fifo_level
);

    seq_state_e       state_q;
    logic             byte_sent_q;
    logic             full;
    logic             empty;
    logic             pop;
    logic [WIDTH-1:0] head;
    logic             st_busy;
    logic             st_done;
    logic             unused_rd;

    assign st_busy   = rf_rd_data[ST_BUSY_BIT];
    assign st_done   = rf_rd_data[ST_DONE_BIT];
    assign unused_rd = ^rf_rd_data[WIDTH-1:2];

    assign pop       = (state_q == WR_DATA);
    assign s_ready   = !full;
    assign seq_busy  = (state_q != IDLE) || !empty;
    assign byte_sent = byte_sent_q;

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .arst_n  (arst_n),
        .push_i  (s_valid),
        .wdata_i (s_data),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty),
        .level_o (fifo_level)
    );

    always_comb begin
        rf_wr_en   = 1'b0;
        rf_wr_addr = CONTROL_ADDR;
        rf_wr_data = '0;
        rf_rd_en   = 1'b0;
        rf_rd_addr = STATUS_ADDR;
        unique case (state_q)
            WR_DATA: begin
                rf_wr_en   = 1'b1;
                rf_wr_addr = DATA_TX_ADDR;
                rf_wr_data = head;
            end
            WR_START: begin
                rf_wr_en   = 1'b1;
                rf_wr_data = CTRL_START;
            end
            WR_CLEAR: rf_wr_en = 1'b1;
            RD_BUSY:  rf_rd_en = 1'b1;
            RD_DONE:  rf_rd_en = 1'b1;
            default: ;
        endcase
    end

`ifdef UART_SEQ_TIMEOUT_EN
    logic [15:0] cnt_q;
    logic        tmo_q;
    logic        polling;

    assign polling = (state_q == RD_BUSY) || (state_q == CHK_BUSY)
                  || (state_q == RD_DONE) || (state_q == CHK_DONE);
    assign timeout_err = tmo_q;
`endif

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q     <= IDLE;
            byte_sent_q <= 1'b0;
`ifdef UART_SEQ_TIMEOUT_EN
            cnt_q       <= '0;
            tmo_q       <= 1'b0;
`endif
        end else begin
            byte_sent_q <= 1'b0;
            unique case (state_q)
                IDLE:     if (enable && !empty) state_q <= WR_DATA;
                WR_DATA:  state_q <= WR_START;
                WR_START: state_q <= WR_CLEAR;
                WR_CLEAR: state_q <= RD_BUSY;
                RD_BUSY:  state_q <= CHK_BUSY;
                // Busy must be seen first so a stale done is never taken
                CHK_BUSY: state_q <= st_busy ? RD_DONE : RD_BUSY;
                RD_DONE:  state_q <= CHK_DONE;
                CHK_DONE: begin
                    if (st_done && !st_busy) begin
                        state_q     <= IDLE;
                        byte_sent_q <= 1'b1;
                    end else begin
                        state_q <= RD_DONE;
                    end
                end
                default:  state_q <= IDLE;
            endcase
`ifdef UART_SEQ_TIMEOUT_EN
            if (state_q == WR_CLEAR) begin
                cnt_q <= '0;
            end else if (polling) begin
                cnt_q <= cnt_q + 16'd1;
                if (cnt_q == TIMEOUT_CYCLES - 16'd1) begin
                    state_q     <= IDLE;
                    byte_sent_q <= 1'b0;
                    tmo_q       <= 1'b1;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Bench for uart_tx_sequencer: register-file/UART model plus
// byte-stream reference checked against the logged bus writes.
module tb_uart_tx_sequencer;

    logic       clk = 1'b0;
    logic       arst_n;
    logic       enable;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_ready;
    logic       rf_wr_en;
    logic [1:0] rf_wr_addr;
    logic [7:0] rf_wr_data;
    logic       rf_rd_en;
    logic [1:0] rf_rd_addr;
    logic [7:0] rf_rd_data;
    logic       seq_busy;
    logic       byte_sent;
    logic [2:0] fifo_level;
`ifdef UART_SEQ_TIMEOUT_EN
    logic       timeout_err;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_sequencer #(
        .WIDTH      (8),
        .DEPTH      (4),
`ifdef UART_SEQ_TIMEOUT_EN
        .TIMEOUT_CYCLES (16'd100),
`endif
        .CTRL_START (8'h01)
    ) dut (
        .clk        (clk),
        .arst_n     (arst_n),
        .enable     (enable),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .rf_wr_en   (rf_wr_en),
        .rf_wr_addr (rf_wr_addr),
        .rf_wr_data (rf_wr_data),
        .rf_rd_en   (rf_rd_en),
        .rf_rd_addr (rf_rd_addr),
        .rf_rd_data (rf_rd_data),
`ifdef UART_SEQ_TIMEOUT_EN
        .timeout_err (timeout_err),
`endif
        .seq_busy   (seq_busy),
        .byte_sent  (byte_sent),
        .fifo_level (fifo_level)
    );

    // UART + register-file model; delay 0 means "never"
    int   busy_dly;
    int   done_dly;
    int   t;
    logic act;
    logic u_busy;
    logic u_done;
    int   done_cyc_q[$];

    always @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            act        <= 1'b0;
            t          <= 0;
            u_busy     <= 1'b0;
            u_done     <= 1'b0;
            rf_rd_data <= 8'h00;
        end else begin
            if (rf_wr_en && rf_wr_addr == 2'd0 && rf_wr_data == 8'h01) begin
                act <= 1'b1;
                t   <= 0;
            end else if (act) begin
                t <= t + 1;
                if (t + 1 == busy_dly) begin
                    u_busy <= 1'b1;
                    u_done <= 1'b0;
                end
                if (t + 1 == done_dly) begin
                    u_busy <= 1'b0;
                    u_done <= 1'b1;
                    act    <= 1'b0;
                    done_cyc_q.push_back(cyc);
                end
            end
            if (rf_rd_en) rf_rd_data <= {6'b0, u_busy, u_done};
        end
    end

    // Bus monitor
    int         wr_cyc[$];
    logic [1:0] wr_addr[$];
    logic [7:0] wr_data[$];
    int         sent_cyc[$];
    int         rd_cnt;
    int         rd_bad;
    int         both_bad;

    always @(negedge clk) begin
        if (rf_wr_en) begin
            wr_cyc.push_back(cyc);
            wr_addr.push_back(rf_wr_addr);
            wr_data.push_back(rf_wr_data);
        end
        if (rf_rd_en) rd_cnt++;
        if (rf_rd_en && rf_rd_addr != 2'd2) rd_bad++;
        if (rf_wr_en && rf_rd_en) both_bad++;
        if (byte_sent) sent_cyc.push_back(cyc);
    end

    function automatic void clr_logs();
        wr_cyc.delete();
        wr_addr.delete();
        wr_data.delete();
        sent_cyc.delete();
        done_cyc_q.delete();
        rd_cnt   = 0;
        rd_bad   = 0;
        both_bad = 0;
    endfunction

    // Deviations of the logged traffic from the byte stream exp
    function automatic int stream_errs(input logic [7:0] exp[$]);
        int e = 0;
        if (wr_cyc.size() != 3 * exp.size()) return 1000 + wr_cyc.size();
        if (sent_cyc.size() != exp.size()) e++;
        for (int i = 0; i < exp.size(); i++) begin
            int k = 3 * i;
            if (wr_addr[k] !== 2'd1 || wr_data[k] !== exp[i]) e++;
            if (wr_addr[k+1] !== 2'd0 || wr_data[k+1] !== 8'h01) e++;
            if (wr_addr[k+2] !== 2'd0 || wr_data[k+2] !== 8'h00) e++;
            if (wr_cyc[k+1] != wr_cyc[k] + 1) e++;
            if (wr_cyc[k+2] != wr_cyc[k] + 2) e++;
            if (i < sent_cyc.size() && i < done_cyc_q.size())
                if (sent_cyc[i] <= done_cyc_q[i]) e++;
            if (i > 0 && i - 1 < sent_cyc.size())
                if (wr_cyc[k] <= sent_cyc[i-1]) e++;
        end
        return e;
    endfunction

    task automatic push_byte(input logic [7:0] b);
        int n = 0;
        while (!s_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (!s_ready) begin
            bad++;
            $display("FAIL push_ready: s_ready=%0b, required 1", s_ready);
        end
        s_valid = 1'b1;
        s_data  = b;
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((seq_busy || act) && n < budget) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        total++;
        if (seq_busy !== 1'b0) begin
            bad++;
            $display("FAIL wait_idle: seq_busy=%0b after %0d cycles, required 0",
                     seq_busy, n);
        end
    endtask

    task automatic test_reset;
        for (int ph = 0; ph < 2; ph++) begin
            total++;
            if ({rf_wr_en, rf_rd_en, seq_busy, byte_sent, s_ready} !== 5'b00001
                || fifo_level !== 3'd0 || rf_wr_data !== 8'h00
                || rf_wr_addr !== 2'd0) begin
                bad++;
                $display("FAIL reset_outputs[%0d]: wr=%0b rd=%0b busy=%0b sent=%0b rdy=%0b lvl=%0d, required 0 0 0 0 1 0",
                         ph, rf_wr_en, rf_rd_en, seq_busy, byte_sent, s_ready, fifo_level);
            end
            arst_n = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic test_single;
        logic [7:0] exp[$];
        int e;
        clr_logs();
        busy_dly = 3;
        done_dly = 20;
        enable   = 1'b1;
        push_byte(8'hA5);
        exp.push_back(8'hA5);
        wait_idle(500);
        e = stream_errs(exp);
        total++;
        if (e !== 0) begin
            bad++;
            $display("FAIL single_stream: %0d deviations (writes=%0d sent=%0d), required 0",
                     e, wr_cyc.size(), sent_cyc.size());
        end
        total++;
        if (rd_cnt < 2 || rd_bad !== 0 || both_bad !== 0) begin
            bad++;
            $display("FAIL single_reads: reads=%0d bad_addr=%0d both_en=%0d, required >=2 0 0",
                     rd_cnt, rd_bad, both_bad);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp[$];
        logic [7:0] vals[4];
        int e;
        vals = '{8'h11, 8'h22, 8'h33, 8'h44};
        clr_logs();
        enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1;
            s_data  = vals[i];
            exp.push_back(vals[i]);
            @(negedge clk);
        end
        s_data = 8'h55;
        total++;
        if (s_ready !== 1'b0 || fifo_level !== 3'd4) begin
            bad++;
            $display("FAIL b2b_full: s_ready=%0b level=%0d, required 0 4",
                     s_ready, fifo_level);
        end
        @(negedge clk);
        s_valid = 1'b0;
        total++;
        if (fifo_level !== 3'd4) begin
            bad++;
            $display("FAIL b2b_drop: level=%0d, required 4", fifo_level);
        end
        enable = 1'b1;
        wait_idle(2000);
        e = stream_errs(exp);
        total++;
        if (e !== 0) begin
            bad++;
            $display("FAIL b2b_stream: %0d deviations (writes=%0d sent=%0d), required 0",
                     e, wr_cyc.size(), sent_cyc.size());
        end
    endtask

    task automatic test_stale_done;
        logic [7:0] exp[$];
        int e;
        clr_logs();
        busy_dly = 14;
        done_dly = 26;
        total++;
        if (u_done !== 1'b1 || u_busy !== 1'b0) begin
            bad++;
            $display("FAIL stale_setup: done=%0b busy=%0b, required 1 0", u_done, u_busy);
        end
        push_byte(8'h3C);
        exp.push_back(8'h3C);
        wait_idle(500);
        e = stream_errs(exp);
        total++;
        if (e !== 0) begin
            bad++;
            $display("FAIL stale_stream: %0d deviations (sent=%0d), required 0",
                     e, sent_cyc.size());
        end
    endtask

    task automatic test_enable;
        logic [7:0] exp[$];
        int e;
        clr_logs();
        busy_dly = 2;
        done_dly = 9;
        enable   = 1'b0;
        push_byte(8'hC3);
        push_byte(8'h5A);
        exp = '{8'hC3, 8'h5A};
        repeat (20) @(negedge clk);
        total++;
        if (wr_cyc.size() !== 0 || fifo_level !== 3'd2 || seq_busy !== 1'b1) begin
            bad++;
            $display("FAIL enable_hold: writes=%0d level=%0d busy=%0b, required 0 2 1",
                     wr_cyc.size(), fifo_level, seq_busy);
        end
        enable = 1'b1;
        wait_idle(1000);
        e = stream_errs(exp);
        total++;
        if (e !== 0) begin
            bad++;
            $display("FAIL enable_resume: %0d deviations, required 0", e);
        end
    endtask

    task automatic test_random;
        logic [7:0] exp[$];
        int e;
        for (int r = 0; r < 3; r++) begin
            clr_logs();
            exp.delete();
            busy_dly = $urandom_range(1, 8);
            done_dly = busy_dly + $urandom_range(1, 25);
            for (int i = 0; i < 6; i++) begin
                logic [7:0] b;
                b = 8'($urandom);
                push_byte(b);
                exp.push_back(b);
                repeat ($urandom_range(0, 30)) @(negedge clk);
            end
            wait_idle(3000);
            e = stream_errs(exp);
            total++;
            if (e !== 0 || both_bad !== 0 || rd_bad !== 0) begin
                bad++;
                $display("FAIL random_stream[%0d]: dev=%0d both=%0d rdaddr=%0d, required 0 0 0",
                         r, e, both_bad, rd_bad);
            end
        end
    endtask

    task automatic test_async_reset;
        int n = 0;
        clr_logs();
        busy_dly = 3;
        done_dly = 0;
        enable   = 1'b0;
        push_byte(8'h01);
        push_byte(8'h02);
        push_byte(8'h03);
        enable = 1'b1;
        while (!(rf_rd_en && rf_rd_data[1]) && n < 300) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (!(rf_rd_en && rf_rd_data[1]) || fifo_level !== 3'd2) begin
            bad++;
            $display("FAIL arst_reach: rd_en=%0b busy_rd=%0b level=%0d, required 1 1 2",
                     rf_rd_en, rf_rd_data[1], fifo_level);
        end
        arst_n = 1'b0;
        #1;
        total++;
        if ({rf_wr_en, rf_rd_en, seq_busy, byte_sent, s_ready} !== 5'b00001
            || fifo_level !== 3'd0) begin
            bad++;
            $display("FAIL arst_outputs: wr=%0b rd=%0b busy=%0b sent=%0b rdy=%0b lvl=%0d, required 0 0 0 0 1 0",
                     rf_wr_en, rf_rd_en, seq_busy, byte_sent, s_ready, fifo_level);
        end
        @(negedge clk);
        clr_logs();
        arst_n = 1'b1;
        repeat (30) @(negedge clk);
        total++;
        if (wr_cyc.size() !== 0 || rd_cnt !== 0 || sent_cyc.size() !== 0
            || fifo_level !== 3'd0) begin
            bad++;
            $display("FAIL arst_quiet: writes=%0d reads=%0d sent=%0d lvl=%0d, required 0 0 0 0",
                     wr_cyc.size(), rd_cnt, sent_cyc.size(), fifo_level);
        end
    endtask

`ifdef UART_SEQ_TIMEOUT_EN
    task automatic test_timeout;
        int n = 0;
        int start;
        clr_logs();
        busy_dly = 0;
        done_dly = 0;
        enable   = 1'b1;
        push_byte(8'h77);
        while (wr_cyc.size() < 3 && n < 50) begin
            @(negedge clk);
            n++;
        end
        start = (wr_cyc.size() >= 3) ? wr_cyc[2] : cyc;
        n = 0;
        while (!timeout_err && n < 400) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (timeout_err !== 1'b1 || cyc - start < 100 || cyc - start > 102) begin
            bad++;
            $display("FAIL timeout_time: err=%0b delay=%0d, required 1 and 100..102",
                     timeout_err, cyc - start);
        end
        repeat (3) @(negedge clk);
        total++;
        if (sent_cyc.size() !== 0 || seq_busy !== 1'b0 || timeout_err !== 1'b1) begin
            bad++;
            $display("FAIL timeout_state: sent=%0d busy=%0b err=%0b, required 0 0 1",
                     sent_cyc.size(), seq_busy, timeout_err);
        end
    endtask
`endif

    initial begin
        arst_n   = 1'b0;
        enable   = 1'b0;
        s_valid  = 1'b0;
        s_data   = 8'h00;
        busy_dly = 3;
        done_dly = 20;
        clr_logs();
        repeat (3) @(negedge clk);
        test_reset;
        test_single;
        test_back_to_back;
        test_stale_done;
        test_enable;
        test_random;
        test_async_reset;
`ifdef UART_SEQ_TIMEOUT_EN
        test_timeout;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
